// File: rtl/uart_rx_fifo_if.sv
// Receive-side buffer bus: receiver capture, consumer valid/ready read side and status flags.
// The slave modport is the buffer; the master modport is the receiver/consumer side.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              rx_done;
  logic [DATA_W-1:0] rx_dat;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              clr_ovf;
  logic              almost_full;

  modport slave (
    input  rx_done, rx_dat, rd_ready, clr_ovf,
    output rd_data, rd_valid, count, full, empty, overflow, almost_full
  );

  modport master (
    output rx_done, rx_dat, rd_ready, clr_ovf,
    input  rd_data, rd_valid, count, full, empty, overflow, almost_full
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO: edge-captures rx_done, first-word-fall-through read, sticky overflow.
// Optional registered almost_full watermark enabled by defining RXF_WATERMARK_EN.
module uart_rx_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);

  if (DEPTH != (2 ** ADDR_W) || DEPTH < 2 || AFULL_LVL > DEPTH) begin : g_param_check
    $error("uart_rx_fifo: bad DEPTH/ADDR_W/AFULL_LVL combination");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              done_q;
  logic              wr_req, rd_fire, wr_acc;
`ifdef RXF_WATERMARK_EN
  logic              afull_q, afull_d;
`endif

  always_comb begin
    wr_req  = bus.rx_done && !done_q;
    rd_fire = !empty_q && bus.rd_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    wr_acc  = wr_req && (!full_q || rd_fire);

    wptr_d  = wr_acc  ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rd_fire ? rptr_q + 1'b1 : rptr_q;

    count_d = count_q;
    case ({wr_acc, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d = (count_d == '0);

    ovf_d = ovf_q;
    if (bus.clr_ovf)         ovf_d = 1'b0;
    if (wr_req && !wr_acc)   ovf_d = 1'b1;

`ifdef RXF_WATERMARK_EN
    afull_d = (count_d >= (ADDR_W+1)'(AFULL_LVL));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef RXF_WATERMARK_EN
      afull_q <= 1'b0;
`endif
    end else begin
      done_q  <= bus.rx_done;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
`ifdef RXF_WATERMARK_EN
      afull_q <= afull_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= bus.rx_dat;
  end

  // Storage is not reset, so the head is masked to zero while nothing is queued.
  assign bus.rd_data  = empty_q ? '0 : mem_q[rptr_q];
  assign bus.rd_valid = !empty_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = ovf_q;
`ifdef RXF_WATERMARK_EN
  assign bus.almost_full = afull_q;
`else
  assign bus.almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: cycle vector table plus directed multi-cycle sequences.
module tb_uart_rx_fifo;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned AFULL_LVL = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL_LVL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic       done;
    logic [7:0] dat;
    logic       rdy;
    logic       clr;
    int         e_count;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
  } vec_t;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  vec_t        vecs[12];

  function automatic vec_t mk(logic d, logic [7:0] dat, logic r, logic c, int cnt,
                              logic v, logic [7:0] ed, logic f, logic e, logic o);
    vec_t t;
    t.done = d; t.dat = dat; t.rdy = r; t.clr = c; t.e_count = cnt;
    t.e_valid = v; t.e_data = ed; t.e_full = f; t.e_empty = e; t.e_ovf = o;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rx_done  = 1'b0;
    bus.rx_dat   = '0;
    bus.rd_ready = 1'b0;
    bus.clr_ovf  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.rx_dat  = b;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    step();
  endtask

  task automatic fill_seq(input logic [7:0] base);
    for (int i = 0; i < 16; i++) write_byte(base + 8'(i));
  endtask

  task automatic drain_expect(input string tag, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.valid%0d", tag, i), 32'(bus.rd_valid), 32'd1);
      chk($sformatf("%s.data%0d", tag, i), 32'(bus.rd_data), 32'(first + 8'(i)));
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Vector table: inputs applied before an edge, expectations sampled after it.
    vecs[0]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0);
    vecs[1]  = mk(1, 8'h11, 0, 0, 1, 1, 8'h11, 0, 0, 0);
    vecs[2]  = mk(1, 8'h11, 0, 0, 1, 1, 8'h11, 0, 0, 0);
    vecs[3]  = mk(0, 8'h00, 0, 0, 1, 1, 8'h11, 0, 0, 0);
    vecs[4]  = mk(1, 8'h22, 0, 0, 2, 1, 8'h11, 0, 0, 0);
    vecs[5]  = mk(0, 8'h00, 1, 0, 1, 1, 8'h22, 0, 0, 0);
    vecs[6]  = mk(1, 8'h33, 1, 0, 1, 1, 8'h33, 0, 0, 0);
    vecs[7]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 0);
    vecs[8]  = mk(1, 8'h44, 1, 0, 1, 1, 8'h44, 0, 0, 0);
    vecs[9]  = mk(0, 8'h00, 0, 0, 1, 1, 8'h44, 0, 0, 0);
    vecs[10] = mk(0, 8'h00, 0, 1, 1, 1, 8'h44, 0, 0, 0);
    vecs[11] = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 0);

    do_reset();
    chk("rst.count", 32'(bus.count), 32'd0);
    chk("rst.empty", 32'(bus.empty), 32'd1);
    chk("rst.full", 32'(bus.full), 32'd0);
    chk("rst.valid", 32'(bus.rd_valid), 32'd0);
    chk("rst.data", 32'(bus.rd_data), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);
    chk("rst.afull", 32'(bus.almost_full), 32'd0);

    for (int i = 0; i < 12; i++) begin
      bus.rx_done  = vecs[i].done;
      bus.rx_dat   = vecs[i].dat;
      bus.rd_ready = vecs[i].rdy;
      bus.clr_ovf  = vecs[i].clr;
      step();
      chk($sformatf("v%0d.count", i), 32'(bus.count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d.valid", i), 32'(bus.rd_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d.data", i), 32'(bus.rd_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d.full", i), 32'(bus.full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d.empty", i), 32'(bus.empty), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d.ovf", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
    end
    idle_inputs();

    // Long rx_done pulse captures exactly one byte.
    do_reset();
    bus.rx_dat  = 8'h5A;
    bus.rx_done = 1'b1;
    step();
    chk("hold.lat_count", 32'(bus.count), 32'd1);
    chk("hold.lat_valid", 32'(bus.rd_valid), 32'd1);
    chk("hold.lat_data", 32'(bus.rd_data), 32'h5A);
    repeat (1999) step();
    chk("hold.count", 32'(bus.count), 32'd1);
    bus.rx_done = 1'b0;
    step();
    chk("hold.count_after", 32'(bus.count), 32'd1);

    // Fill then drain in order.
    do_reset();
    fill_seq(8'h01);
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.count", 32'(bus.count), 32'd16);
    chk("fill.ovf", 32'(bus.overflow), 32'd0);
    drain_expect("drain", 8'h01, 16);
    chk("drain.empty", 32'(bus.empty), 32'd1);
    chk("drain.count", 32'(bus.count), 32'd0);

    // Overflow drops the byte; set beats clear; clear afterwards works.
    do_reset();
    fill_seq(8'h01);
    write_byte(8'h77);
    chk("ovf.flag", 32'(bus.overflow), 32'd1);
    chk("ovf.count", 32'(bus.count), 32'd16);
    bus.rx_dat  = 8'h78;
    bus.rx_done = 1'b1;
    bus.clr_ovf = 1'b1;
    step();
    bus.rx_done = 1'b0;
    bus.clr_ovf = 1'b0;
    chk("ovf.set_wins", 32'(bus.overflow), 32'd1);
    step();
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    chk("ovf.cleared", 32'(bus.overflow), 32'd0);
    drain_expect("ovfdrain", 8'h01, 16);
    chk("ovfdrain.empty", 32'(bus.empty), 32'd1);

    // Full with simultaneous read and write.
    do_reset();
    fill_seq(8'h01);
    bus.rx_dat   = 8'hAB;
    bus.rx_done  = 1'b1;
    bus.rd_ready = 1'b1;
    step();
    bus.rx_done  = 1'b0;
    bus.rd_ready = 1'b0;
    chk("rw.count", 32'(bus.count), 32'd16);
    chk("rw.full", 32'(bus.full), 32'd1);
    chk("rw.ovf", 32'(bus.overflow), 32'd0);
    chk("rw.head", 32'(bus.rd_data), 32'h02);
    step();
    drain_expect("rwdrain", 8'h02, 15);
    chk("rwdrain.last", 32'(bus.rd_data), 32'hAB);
    drain_expect("rwdrain_ab", 8'hAB, 1);
    chk("rwdrain.empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset mid-stream with rx_done held high across release.
    do_reset();
    for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i));
    chk("mrst.pre_count", 32'(bus.count), 32'd5);
    bus.rx_dat  = 8'h99;
    bus.rx_done = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst.count", 32'(bus.count), 32'd0);
    chk("mrst.empty", 32'(bus.empty), 32'd1);
    chk("mrst.valid", 32'(bus.rd_valid), 32'd0);
    chk("mrst.data", 32'(bus.rd_data), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("mrst.no_capture", 32'(bus.count), 32'd0);
    bus.rx_done = 1'b0;
    step();
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    chk("mrst.recap_count", 32'(bus.count), 32'd1);
    chk("mrst.recap_data", 32'(bus.rd_data), 32'h99);

    // Watermark.
    do_reset();
    for (int i = 0; i < 11; i++) write_byte(8'(i));
    chk("wm.af_11", 32'(bus.almost_full), 32'd0);
    write_byte(8'd11);
`ifdef RXF_WATERMARK_EN
    chk("wm.af_12", 32'(bus.almost_full), 32'd1);
`else
    chk("wm.af_12", 32'(bus.almost_full), 32'd0);
`endif
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    chk("wm.af_read", 32'(bus.almost_full), 32'd0);
    chk("wm.count", 32'(bus.count), 32'd11);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
